frame_buffer_writer: RTL and testbench
======================================

FRAME_BUFFER_WRITER -- requirements
Module: frame_buffer_writer

Interface
REQ-001 SHALL have parameter DATA_W, default 64: AXI write data width in bits; allowed values 32, 64, 128.
REQ-002 SHALL have parameter PIX_W, default 16: pixel width; DATA_W SHALL be an integer multiple of PIX_W (PPB = DATA_W/PIX_W pixels per beat).
REQ-003 SHALL have parameter BURST_LEN, default 16: beats per AXI burst, 1..256.
REQ-004 SHALL have parameter FRAME_PIXELS, default 76800: pixels per frame; SHALL be a multiple of PPB*BURST_LEN (elaboration error otherwise).
REQ-005 SHALL have parameter NUM_BUFS, default 3: frame buffers in rotation, 2..4.
REQ-006 SHALL have parameters BASE_ADDR (default 32'h1000_0000) and BUF_STRIDE (default 32'h0010_0000), both 4 KB aligned.
REQ-007 Ports (name  dir  width  meaning):
 clk  in  1  single clock (AXI domain); rst_n  in  1  asynchronous active-low reset.
 s_data  in  PIX_W  pixel; s_valid  in  1; s_ready  out  1; s_sof  in  1  first pixel of frame, qualified by s_valid&s_ready.
 awaddr  out  32; awvalid  out  1; awready  in  1; awlen  out  8; awsize  out  3; awburst  out  2.
 wdata  out  DATA_W; wvalid  out  1; wready  in  1; wlast  out  1; wstrb  out  DATA_W/8.
 bvalid  in  1; bready  out  1.
 rd_busy_idx  in  2  buffer the reader is currently scanning.
 done_idx  out  2  last fully written buffer; done_pulse  out  1  one-cycle strobe when done_idx updates.
 frame_cnt  out  16; drop_cnt  out  16  statistics (see Configuration).

Function
REQ-008 Packer SHALL place the first pixel of each beat in bits [PIX_W-1:0], next pixel above; a beat SHALL be pushed into the internal beat FIFO after PPB accepted pixels.
REQ-009 Beat FIFO depth SHALL be 2*BURST_LEN; s_ready SHALL be 1 when the FIFO is not full and the FSM is not in FLUSH.
REQ-010 FSM states IDLE, ADDR, DATA, RESP, FLUSH; IDLE->ADDR when FIFO count >= BURST_LEN; ADDR->DATA on awvalid&awready; DATA->RESP on the wlast beat accepted; RESP->IDLE on bvalid&bready.
REQ-011 awaddr SHALL equal BASE_ADDR + wr_idx*BUF_STRIDE + burst_no*BURST_LEN*(DATA_W/8); awlen = BURST_LEN-1; awsize = log2(DATA_W/8); awburst = 2'b01; wstrb all ones.
REQ-012 awvalid SHALL hold high and awaddr stable until awready; wvalid/wdata SHALL hold until wready; wlast SHALL be high only on beat BURST_LEN-1.
REQ-013 bready SHALL be 1 only in RESP; bresp is ignored.
REQ-014 After the final burst of a frame completes in RESP, done_idx SHALL take wr_idx and done_pulse SHALL assert for one cycle in the same cycle the FSM enters IDLE.
REQ-015 Next wr_idx SHALL be (wr_idx+1) mod NUM_BUFS, advanced once more if that equals rd_busy_idx; with NUM_BUFS=2 the skip SHALL NOT apply.
REQ-016 s_sof accepted when pixel offset != 0 (short frame): a burst in flight SHALL complete normally; FSM then SHALL enter FLUSH, discard FIFO and packer contents, reset offset and burst_no to 0 in the same wr_idx, no done_pulse; the sof pixel SHALL be retained as lane 0 of the new frame.
REQ-017 s_sof at offset 0 SHALL be a no-op; pixels beyond FRAME_PIXELS before the next s_sof SHALL be accepted and discarded.
REQ-018 Latency: awvalid SHALL assert no later than 2 cycles after the FIFO count reaches BURST_LEN.

Reset
REQ-019 While rst_n=0: all valid/ready/strobe outputs 0, awaddr = BASE_ADDR, wr_idx 0, done_idx 0, counters 0, FIFO empty, FSM IDLE.
REQ-020 Reset mid-burst SHALL abandon the transaction immediately; no completion is generated after release.

Configuration
REQ-021 With macro FRAME_BUFFER_WRITER_STATS_EN defined, frame_cnt SHALL increment on each done_pulse and drop_cnt on each short frame, both saturating at 16'hFFFF; without it both SHALL be constant 0 and no counter logic SHALL be inferred.

Verification
REQ-022 Defaults with FRAME_PIXELS=1024 (16 bursts), ready/bvalid always 1: one full frame -> 16 bursts at 0x1000_0000 step 0x80, done_idx=0, one done_pulse.
REQ-023 Pixels 0x0001..0x0004 -> first wdata = 64'h0004_0003_0002_0001.
REQ-024 awready held 0 for 10 cycles -> awaddr/awvalid stable, s_ready drops when FIFO holds 32 beats.
REQ-025 NUM_BUFS=3, rd_busy_idx=1, frame completes in buffer 0 -> next frame addresses start at 0x1020_0000.
REQ-026 s_sof after 300 pixels -> no done_pulse, next frame restarts at buffer offset 0, drop_cnt=1 with STATS_EN.
REQ-027 rst_n pulsed low during DATA beat 5 -> all outputs at reset values asynchronously, first awaddr after release = 0x1000_0000.

Source files
------------

// File: rtl/frame_buffer_writer.sv
// Packs a pixel stream into AXI write bursts across a rotating set of frame buffers.
// Optional statistics counters are enabled by defining FRAME_BUFFER_WRITER_STATS_EN.
module frame_buffer_writer #(
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned PIX_W        = 16,
  parameter int unsigned BURST_LEN    = 16,
  parameter int unsigned FRAME_PIXELS = 76800,
  parameter int unsigned NUM_BUFS     = 3,
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter logic [31:0] BUF_STRIDE   = 32'h0010_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PIX_W-1:0]      s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_sof,
  output logic [31:0]           awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic [DATA_W-1:0]     wdata,
  output logic                  wvalid,
  input  logic                  wready,
  output logic                  wlast,
  output logic [DATA_W/8-1:0]   wstrb,
  input  logic                  bvalid,
  output logic                  bready,
  input  logic [1:0]            rd_busy_idx,
  output logic [1:0]            done_idx,
  output logic                  done_pulse,
  output logic [15:0]           frame_cnt,
  output logic [15:0]           drop_cnt
);

  localparam int unsigned PPB         = DATA_W / PIX_W;
  localparam int unsigned STRB_W      = DATA_W / 8;
  localparam int unsigned DEPTH       = 2 * BURST_LEN;
  localparam int unsigned BURSTS      = FRAME_PIXELS / (PPB * BURST_LEN);
  localparam int unsigned PTR_W       = $clog2(DEPTH);
  localparam int unsigned CNT_W       = $clog2(DEPTH + 1);
  localparam int unsigned LANE_W      = (PPB > 1) ? $clog2(PPB) : 1;
  localparam int unsigned PIXC_W      = $clog2(FRAME_PIXELS + 1);
  localparam int unsigned BNO_W       = (BURSTS > 1) ? $clog2(BURSTS) : 1;
  localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * STRB_W);

  if (!(DATA_W == 32 || DATA_W == 64 || DATA_W == 128)) begin : g_bad_data_w
    $error("DATA_W must be 32, 64 or 128");
  end
  if (PIX_W == 0 || (DATA_W % PIX_W) != 0) begin : g_bad_pix_w
    $error("DATA_W must be an integer multiple of PIX_W");
  end
  if (BURST_LEN < 1 || BURST_LEN > 256) begin : g_bad_burst
    $error("BURST_LEN must be 1..256");
  end
  if (FRAME_PIXELS == 0 || (FRAME_PIXELS % (PPB * BURST_LEN)) != 0) begin : g_bad_frame
    $error("FRAME_PIXELS must be a multiple of PPB*BURST_LEN");
  end
  if (NUM_BUFS < 2 || NUM_BUFS > 4) begin : g_bad_bufs
    $error("NUM_BUFS must be 2..4");
  end
  if (BASE_ADDR[11:0] != 12'h000 || BUF_STRIDE[11:0] != 12'h000) begin : g_bad_align
    $error("BASE_ADDR and BUF_STRIDE must be 4 KB aligned");
  end

  typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_RESP, ST_FLUSH} state_t;

  state_t               state_q, state_d;
  logic [DATA_W-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [DATA_W-1:0]    pack_q, pack_d, push_data;
  logic [LANE_W-1:0]    lane_q, lane_d;
  logic [PIXC_W-1:0]    pix_cnt_q, pix_cnt_d;
  logic                 flush_pend_q, flush_pend_d;
  logic [PIX_W-1:0]     hold_q, hold_d;
  logic [7:0]           beat_q, beat_d;
  logic [BNO_W-1:0]     burst_no_q, burst_no_d;
  logic [1:0]           wr_idx_q, wr_idx_d;
  logic [1:0]           done_idx_q, done_idx_d;
  logic                 done_pulse_q, done_pulse_d;
  logic                 accept, frame_full, short_sof, push, pop, clear;

  function automatic logic [1:0] next_idx(input logic [1:0] cur, input logic [1:0] busy);
    logic [1:0] n;
    n = (cur == 2'(NUM_BUFS - 1)) ? 2'd0 : cur + 2'd1;
    if (NUM_BUFS > 2 && n == busy) n = (n == 2'(NUM_BUFS - 1)) ? 2'd0 : n + 2'd1;
    return n;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Input stalls while a short-frame restart is pending so no new-frame beat lands in the FIFO before it is flushed.
  assign s_ready    = rst_n && (count_q != CNT_W'(DEPTH)) && (state_q != ST_FLUSH) && !flush_pend_q;
  assign accept     = s_valid && s_ready;
  assign frame_full = (pix_cnt_q == PIXC_W'(FRAME_PIXELS));
  assign short_sof  = accept && s_sof && (pix_cnt_q != '0) && !frame_full;

  always_comb begin
    pack_d       = pack_q;
    lane_d       = lane_q;
    pix_cnt_d    = pix_cnt_q;
    flush_pend_d = flush_pend_q;
    hold_d       = hold_q;
    push         = 1'b0;
    if (state_q == ST_FLUSH) begin
      // The sof pixel that caused the flush becomes lane 0 of the restarted frame.
      flush_pend_d           = 1'b0;
      pack_d                 = '0;
      pack_d[PIX_W-1:0]      = hold_q;
      pix_cnt_d              = PIXC_W'(1);
      lane_d                 = (PPB == 1) ? '0 : LANE_W'(1);
      push                   = (PPB == 1);
    end else if (short_sof) begin
      flush_pend_d = 1'b1;
      hold_d       = s_data;
    end else if (accept && (s_sof || !frame_full)) begin
      pack_d[lane_q*PIX_W +: PIX_W] = s_data;
      pix_cnt_d = (s_sof ? '0 : pix_cnt_q) + 1'b1;
      if (lane_q == LANE_W'(PPB - 1)) begin
        push   = 1'b1;
        lane_d = '0;
      end else begin
        lane_d = lane_q + 1'b1;
      end
    end
    push_data = pack_d;
  end

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    burst_no_d   = burst_no_q;
    wr_idx_d     = wr_idx_q;
    done_idx_d   = done_idx_q;
    done_pulse_d = 1'b0;
    pop          = 1'b0;
    clear        = 1'b0;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    wlast        = 1'b0;
    bready       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (flush_pend_q) state_d = ST_FLUSH;
        else if (count_q >= CNT_W'(BURST_LEN)) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        awvalid = 1'b1;
        if (awready) begin
          state_d = ST_DATA;
          beat_d  = '0;
        end
      end
      ST_DATA: begin
        wvalid = 1'b1;
        wlast  = (beat_q == 8'(BURST_LEN - 1));
        if (wready) begin
          pop    = 1'b1;
          beat_d = beat_q + 1'b1;
          if (wlast) state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        bready = 1'b1;
        if (bvalid) begin
          state_d = ST_IDLE;
          if (burst_no_q == BNO_W'(BURSTS - 1)) begin
            burst_no_d   = '0;
            done_idx_d   = wr_idx_q;
            done_pulse_d = 1'b1;
            wr_idx_d     = next_idx(wr_idx_q, rd_busy_idx);
          end else begin
            burst_no_d = burst_no_q + 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        clear      = 1'b1;
        burst_no_d = '0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = push ? PTR_W'(1) : '0;
      count_d  = push ? CNT_W'(1) : '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[clear ? '0 : wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pack_q       <= '0;
      lane_q       <= '0;
      pix_cnt_q    <= '0;
      flush_pend_q <= 1'b0;
      hold_q       <= '0;
      beat_q       <= '0;
      burst_no_q   <= '0;
      wr_idx_q     <= '0;
      done_idx_q   <= '0;
      done_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      pack_q       <= pack_d;
      lane_q       <= lane_d;
      pix_cnt_q    <= pix_cnt_d;
      flush_pend_q <= flush_pend_d;
      hold_q       <= hold_d;
      beat_q       <= beat_d;
      burst_no_q   <= burst_no_d;
      wr_idx_q     <= wr_idx_d;
      done_idx_q   <= done_idx_d;
      done_pulse_q <= done_pulse_d;
    end
  end

  assign awaddr     = BASE_ADDR + 32'(wr_idx_q) * BUF_STRIDE + 32'(burst_no_q) * BURST_BYTES;
  assign awlen      = 8'(BURST_LEN - 1);
  assign awsize     = 3'($clog2(STRB_W));
  assign awburst    = 2'b01;
  assign wdata      = mem_q[rd_ptr_q];
  assign wstrb      = '1;
  assign done_idx   = done_idx_q;
  assign done_pulse = done_pulse_q;

`ifdef FRAME_BUFFER_WRITER_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d, drop_cnt_q, drop_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (done_pulse_d && frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + 1'b1;
    if (short_sof && drop_cnt_q != '1)     drop_cnt_d  = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;
`else
  assign frame_cnt = '0;
  assign drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Randomised bench for frame_buffer_writer against a pixel-level frame model.
module tb_frame_buffer_writer;
  localparam int unsigned FP     = 1024;
  localparam int unsigned PPB    = 4;
  localparam int unsigned BL     = 16;
  localparam int unsigned BURSTS = FP / (PPB * BL);
  localparam int unsigned NB     = 3;
`ifdef FRAME_BUFFER_WRITER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_valid = 1'b0, s_sof = 1'b0, s_ready;
  logic [31:0] awaddr;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready, done_pulse;
  logic [7:0]  awlen, wstrb;
  logic [2:0]  awsize;
  logic [1:0]  awburst, done_idx;
  logic [1:0]  rd_busy_idx = 2'd1;
  logic [63:0] wdata;
  logic [15:0] frame_cnt, drop_cnt;

  bit   rand_bp = 1'b0;
  logic aw_hold = 1'b1, w_hold = 1'b1, b_hold = 1'b1;
  logic aw_rnd = 1'b1, w_rnd = 1'b1, b_rnd = 1'b1;
  assign awready = rand_bp ? aw_rnd : aw_hold;
  assign wready  = rand_bp ? w_rnd  : w_hold;
  assign bvalid  = rand_bp ? b_rnd  : b_hold;
  always @(posedge clk) begin
    #2;
    aw_rnd = ($urandom % 4) != 0;
    w_rnd  = ($urandom % 3) != 0;
    b_rnd  = ($urandom % 2) != 0;
  end

  frame_buffer_writer #(
    .DATA_W(64), .PIX_W(16), .BURST_LEN(BL), .FRAME_PIXELS(FP), .NUM_BUFS(NB),
    .BASE_ADDR(32'h1000_0000), .BUF_STRIDE(32'h0010_0000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .wdata(wdata), .wvalid(wvalid), .wready(wready), .wlast(wlast),
    .wstrb(wstrb), .bvalid(bvalid), .bready(bready), .rd_busy_idx(rd_busy_idx),
    .done_idx(done_idx), .done_pulse(done_pulse), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );

  int unsigned n_tests = 0, n_fail = 0;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Frame model: what the memory should see, derived from the accepted pixel sequence.
  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_beat_q[$];
  int unsigned exp_done_q[$];
  logic [15:0] m_pix[$];
  int unsigned m_off = 0, m_buf = 0, m_bno = 0, m_frames = 0, m_drops = 0;

  function automatic int unsigned model_next(input int unsigned b, input int unsigned busy);
    int unsigned n;
    n = (b + 1) % NB;
    if (NB > 2 && n == busy) n = (n + 1) % NB;
    return n;
  endfunction

  task automatic model_reset();
    exp_addr_q.delete(); exp_beat_q.delete(); exp_done_q.delete(); m_pix.delete();
    m_off = 0; m_buf = 0; m_bno = 0; m_frames = 0; m_drops = 0;
  endtask

  task automatic model_pixel(input logic [15:0] p, input logic sof);
    logic [63:0] w;
    if (sof && m_off != 0 && m_off != FP) begin
      m_drops++; m_bno = 0; m_off = 0; m_pix.delete();
    end else if (sof) begin
      m_off = 0;
    end else if (m_off == FP) begin
      return;
    end
    m_pix.push_back(p);
    m_off++;
    if (m_pix.size() == PPB * BL) begin
      exp_addr_q.push_back(32'h1000_0000 + m_buf * 32'h0010_0000 + m_bno * BL * 8);
      for (int b = 0; b < BL; b++) begin
        w = '0;
        for (int l = 0; l < PPB; l++) w = w + (64'(m_pix[b*PPB + l]) << (16 * l));
        exp_beat_q.push_back(w);
      end
      m_pix.delete();
      m_bno++;
      if (m_bno == BURSTS) begin
        exp_done_q.push_back(m_buf);
        m_frames++;
        m_bno = 0;
        m_buf = model_next(m_buf, rd_busy_idx);
      end
    end
  endtask

  int unsigned mon_beat = 0;
  logic        prev_done = 1'b0;
  bit          first_w_seen = 1'b0;
  logic [63:0] first_wdata = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_beat = 0;
      prev_done = 1'b0;
    end else begin
      if (awvalid && awready) begin
        check("awlen", awlen, BL - 1);
        check("awsize", awsize, 3);
        check("awburst", awburst, 1);
        if (exp_addr_q.size() == 0) check("aw_unexpected", exp_addr_q.size(), 1);
        else check("awaddr", awaddr, exp_addr_q.pop_front());
      end
      if (wvalid && wready) begin
        if (!first_w_seen) begin first_w_seen = 1'b1; first_wdata = wdata; end
        check("wlast", wlast, mon_beat == BL - 1);
        check("wstrb", wstrb, 8'hFF);
        if (exp_beat_q.size() == 0) check("w_unexpected", exp_beat_q.size(), 1);
        else check("wdata", wdata, exp_beat_q.pop_front());
        mon_beat = (mon_beat == BL - 1) ? 0 : mon_beat + 1;
      end
      if (done_pulse) begin
        check("done_width", prev_done, 0);
        if (exp_done_q.size() == 0) check("done_unexpected", exp_done_q.size(), 1);
        else check("done_idx", done_idx, exp_done_q.pop_front());
      end
      prev_done = done_pulse;
    end
  end

  task automatic send_pix(input logic [15:0] p, input logic sof);
    int unsigned t = 0;
    s_data = p; s_sof = sof; s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && t < 2000) begin t++; @(negedge clk); end
    if (!s_ready) check("s_ready_timeout", s_ready, 1);
    else model_pixel(p, sof);
    @(posedge clk); #1;
    s_valid = 1'b0; s_sof = 1'b0;
  endtask

  task automatic send_pixels(input int unsigned n, input bit sof_first, input logic [15:0] base,
                             input bit seq, input int unsigned max_gap);
    logic [15:0] p;
    for (int unsigned i = 0; i < n; i++) begin
      p = seq ? base + 16'(i) : 16'($urandom);
      send_pix(p, sof_first && i == 0);
      if (max_gap > 0) begin
        repeat ($urandom_range(max_gap, 0)) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_drain(input string tag);
    int unsigned t = 0;
    while ((exp_addr_q.size() + exp_beat_q.size() + exp_done_q.size()) != 0 && t < 20000) begin
      @(posedge clk); t++;
    end
    check(tag, exp_addr_q.size() + exp_beat_q.size() + exp_done_q.size(), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awvalid"}, awvalid, 0);
    check({tag, "_wvalid"}, wvalid, 0);
    check({tag, "_bready"}, bready, 0);
    check({tag, "_s_ready"}, s_ready, 0);
    check({tag, "_done_pulse"}, done_pulse, 0);
    check({tag, "_awaddr"}, awaddr, 32'h1000_0000);
    check({tag, "_done_idx"}, done_idx, 0);
    check({tag, "_frame_cnt"}, frame_cnt, 0);
    check({tag, "_drop_cnt"}, drop_cnt, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Frame 1: sequential pixels, always-ready bus, reader in buffer 1.
    rd_busy_idx = 2'd1;
    send_pixels(64, 1'b1, 16'h0001, 1'b1, 0);
    t = 0;
    while (!awvalid && t < 10) begin @(posedge clk); #1; t++; end
    check("aw_latency_le2", t <= 2, 1);
    send_pixels(FP - 64, 1'b0, 16'h0041, 1'b1, 0);
    wait_drain("frame1_drain");
    check("first_wdata", first_wdata, 64'h0004_0003_0002_0001);

    // Frame 2: address channel stalled until the FIFO fills.
    aw_hold = 1'b0;
    send_pixels(BL * 2 * PPB, 1'b1, 16'h1000, 1'b1, 0);
    check("s_ready_full", s_ready, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("awvalid_hold", awvalid, 1);
      check("awaddr_hold", awaddr, 32'h1020_0000);
      check("s_ready_hold", s_ready, 0);
    end
    @(posedge clk); #1;
    aw_hold = 1'b1;
    send_pixels(FP - BL * 2 * PPB, 1'b0, 16'h2000, 1'b1, 0);
    wait_drain("frame2_drain");

    // Frame 3: short frame of 300 pixels, then a full restart in the same buffer.
    send_pixels(300, 1'b1, 16'h3000, 1'b1, 0);
    wait_drain("short_drain");
    send_pixels(FP, 1'b1, 16'h4000, 1'b1, 0);
    wait_drain("restart_drain");
    check("drop_cnt", drop_cnt, STATS ? m_drops : 0);

    // Random frames with backpressure, idle gaps and trailing surplus pixels.
    rand_bp = 1'b1;
    for (int f = 0; f < 4; f++) begin
      rd_busy_idx = 2'($urandom_range(3, 0));
      send_pixels(FP + $urandom_range(5, 0), 1'b1, 16'h0, 1'b0, 2);
      wait_drain("rand_drain");
    end
    rand_bp = 1'b0;
    check("frame_cnt", frame_cnt, STATS ? m_frames : 0);

    // Reset asserted while beat 5 of the first burst is on the W channel.
    send_pixels(BL * PPB, 1'b1, 16'h5000, 1'b1, 0);
    t = 0;
    while (!(mon_beat == 5 && wvalid) && t < 100) begin @(posedge clk); #1; t++; end
    check("beat5_reached", mon_beat, 5);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(negedge clk) check("no_late_done", done_pulse, 0);
    @(posedge clk); #1;
    rd_busy_idx = 2'd2;
    send_pixels(FP, 1'b1, 16'h6000, 1'b1, 1);
    wait_drain("post_reset_drain");
    check("post_reset_frame_cnt", frame_cnt, STATS ? m_frames : 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
